// File: rtl/gmii_rx_frame_decoder.sv
// gmii_rx_frame_decoder: strips preamble/SFD, checks and removes FCS, emits GMII payload as byte AXI-Stream
module gmii_rx_frame_decoder #(
  parameter int P_MIN_FRAME_LEN = 64,
  parameter int P_MAX_FRAME_LEN = 1518,
  parameter bit P_CHECK_CRC = 1'b1
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_gmii_rx_dv,
  input  logic       i_gmii_rx_err,
  input  logic [7:0] i_gmii_rx_d,
  output logic [7:0] o_rx_tdata,
  output logic       o_rx_tvalid,
  output logic       o_rx_tlast,
  output logic       o_rx_tuser,
  output logic       o_stat_good,
  output logic       o_stat_bad,
  output logic       o_stat_dropped
);
  typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD, DROP} state_t;
  localparam logic [15:0] MIN_LEN = 16'(P_MIN_FRAME_LEN);
  localparam logic [15:0] MAX_LEN = 16'(P_MAX_FRAME_LEN);
  localparam logic [31:0] RESIDUE = 32'hDEBB20E3;
  state_t state_q, state_d;
  logic dv_prev_q;
  logic [39:0] sr_q, sr_d;
  logic [15:0] len_q, len_d;
  logic [31:0] crc_q, crc_d;
  logic err_q, err_d, frame_bad;
  logic [7:0] tdata_q, tdata_d;
  logic tvalid_q, tvalid_d, tlast_q, tlast_d, tuser_q, tuser_d;
  logic good_q, good_d, bad_q, bad_d, dropped_q, dropped_d;
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
    return r;
  endfunction
  assign frame_bad = (P_CHECK_CRC && crc_q != RESIDUE) || err_q || len_q < MIN_LEN;
  always_comb begin
    state_d = state_q;
    sr_d = sr_q;
    len_d = len_q;
    crc_d = crc_q;
    err_d = err_q;
    tdata_d = '0;
    tvalid_d = 1'b0;
    tlast_d = 1'b0;
    tuser_d = 1'b0;
    good_d = 1'b0;
    bad_d = 1'b0;
    dropped_d = 1'b0;
    case (state_q)
      IDLE: begin
        len_d = '0;
        crc_d = '1;
        err_d = 1'b0;
        if (i_gmii_rx_dv && !dv_prev_q) begin
          state_d = i_gmii_rx_d == 8'h55 ? PREAMBLE : i_gmii_rx_d == 8'hD5 ? PAYLOAD : DROP;
          dropped_d = i_gmii_rx_d != 8'h55 && i_gmii_rx_d != 8'hD5;
        end
      end
      PREAMBLE: begin
        if (!i_gmii_rx_dv) begin
          state_d = IDLE;
          dropped_d = 1'b1;
        end else if (i_gmii_rx_d == 8'hD5) state_d = PAYLOAD;
        else if (i_gmii_rx_d != 8'h55) begin
          state_d = DROP;
          dropped_d = 1'b1;
        end
      end
      PAYLOAD: begin
        if (i_gmii_rx_dv) begin
          sr_d = {sr_q[31:0], i_gmii_rx_d};
          len_d = len_q == 16'hFFFF ? len_q : len_q + 16'd1;
          crc_d = crc_byte(crc_q, i_gmii_rx_d);
          err_d = err_q | i_gmii_rx_err;
          tvalid_d = len_q >= 16'd5;
          tdata_d = len_q >= 16'd5 ? sr_q[39:32] : '0;
          // this push makes the frame one byte too long: close it out as bad
          if (len_q == MAX_LEN) begin
            tlast_d = 1'b1;
            tuser_d = 1'b1;
            bad_d = 1'b1;
            state_d = DROP;
          end
        end else begin
          state_d = IDLE;
          if (len_q >= 16'd5) begin
            tvalid_d = 1'b1;
            tdata_d = sr_q[39:32];
            tlast_d = 1'b1;
            tuser_d = frame_bad;
            good_d = !frame_bad;
            bad_d = frame_bad;
          end else dropped_d = 1'b1;
        end
      end
      default: if (!i_gmii_rx_dv) state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= IDLE;
      dv_prev_q <= 1'b1;
      sr_q <= '0;
      len_q <= '0;
      crc_q <= '1;
      err_q <= 1'b0;
      tdata_q <= '0;
      tvalid_q <= 1'b0;
      tlast_q <= 1'b0;
      tuser_q <= 1'b0;
      good_q <= 1'b0;
      bad_q <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dv_prev_q <= i_gmii_rx_dv;
      sr_q <= sr_d;
      len_q <= len_d;
      crc_q <= crc_d;
      err_q <= err_d;
      tdata_q <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q <= tlast_d;
      tuser_q <= tuser_d;
      good_q <= good_d;
      bad_q <= bad_d;
      dropped_q <= dropped_d;
    end
  end
  assign o_rx_tdata = tdata_q;
  assign o_rx_tvalid = tvalid_q;
  assign o_rx_tlast = tlast_q;
  assign o_rx_tuser = tuser_q;
  assign o_stat_good = good_q;
  assign o_stat_bad = bad_q;
  assign o_stat_dropped = dropped_q;
endmodule
